// File: rtl/seg_frame_loader.sv
// -----------------------------------------------------------------------------
// seg_frame_loader
//   Builds a 64-bit active-low 7-segment frame (8 digits, byte i = digit i,
//   {dp_n, g_n..a_n}) from a 32-bit hex value plus decimal-point and blank
//   masks. It hands the frame to the parallel-to-serial display shifter,
//   pulses start, and then follows the shifter's EN/finish line until the
//   frame has been shifted out.
//   A frame is requested by an update pulse or by the periodic refresh tick.
//
//   Optional build macro: SEG_FRAME_RAW_EN
//     When defined, ports raw_sel/raw_data are added. With raw_sel=1 at the
//     encode cycle, raw_data is loaded verbatim instead of the encoded frame.
// -----------------------------------------------------------------------------
module seg_frame_loader #(
    parameter int REFRESH_CYCLES = 1_000_000,  // 0 disables auto refresh
    parameter int START_WAIT     = 8           // cycles allowed for EN to fall
) (
    input  logic        clk,
    input  logic        rst,        // asynchronous, active-low
    input  logic [31:0] disp_data,
    input  logic [7:0]  point,
    input  logic [7:0]  blank,
    input  logic        update,
    input  logic        p2s_en,     // 1 = shifter idle, 0 = shifting
`ifdef SEG_FRAME_RAW_EN
    input  logic        raw_sel,
    input  logic [63:0] raw_data,
`endif
    output logic [63:0] pdata,
    output logic        start,
    output logic        busy,
    output logic        done,
    output logic        err
);

    // -------------------------------------------------------------------------
    // Local sizing
    // -------------------------------------------------------------------------
    localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [RW-1:0] R_LAST =
        RW'((REFRESH_CYCLES > 0) ? (REFRESH_CYCLES - 1) : 0);

    localparam int WW = (START_WAIT > 1) ? $clog2(START_WAIT) : 1;
    localparam logic [WW-1:0] WAIT_LAST =
        WW'((START_WAIT > 0) ? (START_WAIT - 1) : 0);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_WAIT_LOW  = 2'd2,
        ST_WAIT_HIGH = 2'd3
    } state_t;

    // -------------------------------------------------------------------------
    // Encoding helpers
    // -------------------------------------------------------------------------

    // Active-low segment pattern for one hex digit, decimal point off.
    function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
        logic [7:0] seg;
        case (nib)
            4'h0:    seg = 8'hC0;
            4'h1:    seg = 8'hF9;
            4'h2:    seg = 8'hA4;
            4'h3:    seg = 8'hB0;
            4'h4:    seg = 8'h99;
            4'h5:    seg = 8'h92;
            4'h6:    seg = 8'h82;
            4'h7:    seg = 8'hF8;
            4'h8:    seg = 8'h80;
            4'h9:    seg = 8'h90;
            4'hA:    seg = 8'h88;
            4'hB:    seg = 8'h83;
            4'hC:    seg = 8'hC6;
            4'hD:    seg = 8'hA1;
            4'hE:    seg = 8'h86;
            4'hF:    seg = 8'h8E;
            default: seg = 8'hFF;
        endcase
        return seg;
    endfunction

    // One digit byte: blank wins over the decimal point.
    function automatic logic [7:0] encode_digit(input logic [3:0] nib,
                                                input logic       dp,
                                                input logic       blk);
        logic [7:0] seg;
        seg = hex_to_seg(nib);
        if (blk) begin
            seg = 8'hFF;
        end else begin
            seg[7] = seg[7] & ~dp;
        end
        return seg;
    endfunction

    // Whole frame; digit 0 sits in the low byte so it is shifted out first.
    function automatic logic [63:0] encode_frame(input logic [31:0] data,
                                                 input logic [7:0]  dps,
                                                 input logic [7:0]  blks);
        logic [63:0] frame;
        frame = 64'hFFFF_FFFF_FFFF_FFFF;
        for (int i = 0; i < 8; i++) begin
            frame[8*i +: 8] = encode_digit(data[4*i +: 4], dps[i], blks[i]);
        end
        return frame;
    endfunction

    // -------------------------------------------------------------------------
    // Registers and combinational nets
    // -------------------------------------------------------------------------
    state_t          state_r;
    state_t          state_nx_s;
    logic [WW-1:0]   wait_cnt_r;
    logic [WW-1:0]   wait_cnt_nx_s;
    logic            pending_r;
    logic            pending_nx_s;
    logic [63:0]     pdata_r;
    logic            start_r;
    logic            busy_r;
    logic            done_r;
    logic            err_r;

    logic            refresh_wrap_s;
    logic            launch_s;
    logic            timeout_s;
    logic            finish_s;
    logic [63:0]     frame_s;

    // -------------------------------------------------------------------------
    // Refresh tick
    // -------------------------------------------------------------------------
    generate
        if (REFRESH_CYCLES > 0) begin : g_refresh
            logic [RW-1:0] refresh_cnt_r;

            // Free-running refresh counter; wraps after REFRESH_CYCLES cycles.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    refresh_cnt_r <= {RW{1'b0}};
                end else if (refresh_cnt_r == R_LAST) begin
                    refresh_cnt_r <= {RW{1'b0}};
                end else begin
                    refresh_cnt_r <= refresh_cnt_r + 1'b1;
                end
            end

            assign refresh_wrap_s = (refresh_cnt_r == R_LAST);
        end else begin : g_no_refresh
            assign refresh_wrap_s = 1'b0;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Frame source selection
    // -------------------------------------------------------------------------

    // Frame that would be latched if an encode happened this cycle.
    always_comb begin
        frame_s = encode_frame(disp_data, point, blank);
`ifdef SEG_FRAME_RAW_EN
        if (raw_sel) begin
            frame_s = raw_data;
        end else begin
            frame_s = encode_frame(disp_data, point, blank);
        end
`endif
    end

    // -------------------------------------------------------------------------
    // Control FSM
    // -------------------------------------------------------------------------

    // Next-state, wait counter and event decode for the frame handshake.
    always_comb begin
        state_nx_s    = state_r;
        wait_cnt_nx_s = wait_cnt_r;
        launch_s      = 1'b0;
        timeout_s     = 1'b0;
        finish_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // A request seen while the shifter is busy stays pending.
                if ((pending_r | update) & p2s_en) begin
                    launch_s   = 1'b1;
                    state_nx_s = ST_START;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_START: begin
                wait_cnt_nx_s = {WW{1'b0}};
                state_nx_s    = ST_WAIT_LOW;
            end
            ST_WAIT_LOW: begin
                if (!p2s_en) begin
                    state_nx_s = ST_WAIT_HIGH;
                end else if (wait_cnt_r == WAIT_LAST) begin
                    // Shifter never acknowledged the start: give up.
                    timeout_s  = 1'b1;
                    state_nx_s = ST_IDLE;
                end else begin
                    wait_cnt_nx_s = wait_cnt_r + 1'b1;
                end
            end
            ST_WAIT_HIGH: begin
                if (p2s_en) begin
                    finish_s   = 1'b1;
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_WAIT_HIGH;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Request coalescing: any number of requests collapse into one frame.
    always_comb begin
        if (launch_s) begin
            pending_nx_s = 1'b0;
        end else begin
            pending_nx_s = pending_r | update | refresh_wrap_s;
        end
    end

    // State register and wait counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            wait_cnt_r <= {WW{1'b0}};
        end else begin
            state_r    <= state_nx_s;
            wait_cnt_r <= wait_cnt_nx_s;
        end
    end

    // Pending request flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_r <= 1'b0;
        end else begin
            pending_r <= pending_nx_s;
        end
    end

    // Frame register: loaded only at the encode cycle, held otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pdata_r <= 64'hFFFF_FFFF_FFFF_FFFF;
        end else if (launch_s) begin
            pdata_r <= frame_s;
        end else begin
            pdata_r <= pdata_r;
        end
    end

    // Registered status outputs, decoded from the next state so they line
    // up exactly with the state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            start_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            start_r <= (state_nx_s == ST_START);
            busy_r  <= (state_nx_s != ST_IDLE);
            done_r  <= finish_s;
            err_r   <= err_r | timeout_s;
        end
    end

    assign pdata = pdata_r;
    assign start = start_r;
    assign busy  = busy_r;
    assign done  = done_r;
    assign err   = err_r;

endmodule

// File: tb/tb_seg_frame_loader.sv
// -----------------------------------------------------------------------------
// tb_seg_frame_loader
//   dut_a: auto refresh disabled, driven by explicit update pulses and a
//          behavioural shifter model (programmable shift length, stuck mode,
//          forced-busy override).
//   dut_b: REFRESH_CYCLES=16, no updates; its start pulses must be periodic.
//   Expected frames come from a table-driven digit model.
// -----------------------------------------------------------------------------
module tb_seg_frame_loader;

    localparam int SW = 8;

    logic        clk = 1'b0;
    logic        rst_a;
    logic        rst_b;
    logic [31:0] disp;
    logic [7:0]  point;
    logic [7:0]  blank;
    logic        update_a;
    logic        en_model;
    logic        hold_low;
    logic        en_a;
    logic        en_b;
    logic [63:0] pdata_a;
    logic [63:0] pdata_b;
    logic        start_a, busy_a, done_a, err_a;
    logic        start_b, busy_b, done_b, err_b;

    int n_tests     = 0;
    int n_fail      = 0;
    int shift_len   = 4;
    logic stuck     = 1'b0;
    int starts_a    = 0;
    int dones_a     = 0;
    int starts_b    = 0;
    int cyc         = 0;
    int last_b      = -1;
    int frames_sent = 0;

    always #5 clk = ~clk;

    assign en_a = en_model & ~hold_low;

    seg_frame_loader #(.REFRESH_CYCLES(0), .START_WAIT(SW)) dut_a (
        .clk(clk), .rst(rst_a), .disp_data(disp), .point(point), .blank(blank),
        .update(update_a), .p2s_en(en_a),
`ifdef SEG_FRAME_RAW_EN
        .raw_sel(1'b0), .raw_data(64'd0),
`endif
        .pdata(pdata_a), .start(start_a), .busy(busy_a), .done(done_a), .err(err_a)
    );

    seg_frame_loader #(.REFRESH_CYCLES(16), .START_WAIT(SW)) dut_b (
        .clk(clk), .rst(rst_b), .disp_data(disp), .point(point), .blank(blank),
        .update(1'b0), .p2s_en(en_b),
`ifdef SEG_FRAME_RAW_EN
        .raw_sel(1'b0), .raw_data(64'd0),
`endif
        .pdata(pdata_b), .start(start_b), .busy(busy_b), .done(done_b), .err(err_b)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Digit table lookup; a lit decimal point removes the 0x80 weight.
    function automatic logic [63:0] model_frame(input logic [31:0] d, input logic [7:0] p,
                                                input logic [7:0] b);
        int lut [16];
        logic [63:0] f;
        int v;
        int nib;
        lut = '{32'hC0, 32'hF9, 32'hA4, 32'hB0, 32'h99, 32'h92, 32'h82, 32'hF8,
                32'h80, 32'h90, 32'h88, 32'h83, 32'hC6, 32'hA1, 32'h86, 32'h8E};
        f = 64'd0;
        for (int i = 0; i < 8; i++) begin
            nib = int'((d >> (4 * i)) & 32'hF);
            if (b[i]) begin
                v = 255;
            end else begin
                v = lut[nib];
                if (p[i]) v = v - 128;
            end
            f = f | (64'(v) << (8 * i));
        end
        return f;
    endfunction

    // Shifter for dut_a: EN falls one cycle after start, stays low shift_len cycles.
    initial begin
        en_model = 1'b1;
        forever begin
            @(negedge clk);
            if (start_a && !stuck) begin
                @(negedge clk);
                en_model = 1'b0;
                repeat (shift_len) @(negedge clk);
                en_model = 1'b1;
            end
        end
    end

    // Shifter for dut_b: fixed 5-cycle shift.
    initial begin
        en_b = 1'b1;
        forever begin
            @(negedge clk);
            if (start_b) begin
                @(negedge clk);
                en_b = 1'b0;
                repeat (5) @(negedge clk);
                en_b = 1'b1;
            end
        end
    end

    // Event counters, updated just after each falling edge. dut_b frames take
    // ~7 cycles, well under the 16-cycle period, so starts must be 16 apart.
    always @(negedge clk) begin
        #1;
        cyc++;
        if (start_a) starts_a++;
        if (done_a) dones_a++;
        if (start_b && rst_b) begin
            if (last_b >= 0) check_eq("refresh_period", 64'(cyc - last_b), 64'd16);
            last_b = cyc;
            starts_b++;
        end
    end

    task automatic wait_idle(input string tag);
        int k;
        for (k = 0; k < 300; k++) begin
            if (!busy_a && en_a && !start_a && !done_a) break;
            @(negedge clk);
        end
        check_eq({tag, "_idle_reached"}, 64'(!busy_a && en_a), 64'd1);
    endtask

    task automatic wait_done(input string tag);
        int k;
        for (k = 0; k < 300; k++) begin
            if (done_a) break;
            @(negedge clk);
        end
        check_eq({tag, "_done_seen"}, 64'(done_a), 64'd1);
    endtask

    // One complete frame: request, latency, content, hold, done, pulse counts.
    task automatic send_frame(input logic [31:0] d, input logic [7:0] p, input logic [7:0] b,
                              input logic [63:0] exp, input string tag);
        int s0;
        int d0;
        wait_idle(tag);
        disp = d; point = p; blank = b;
        update_a = 1'b1;
        s0 = starts_a; d0 = dones_a;
        @(negedge clk);
        update_a = 1'b0;
        frames_sent++;
        check_eq({tag, "_start"}, 64'(start_a), 64'd1);
        check_eq({tag, "_pdata"}, pdata_a, exp);
        check_eq({tag, "_busy"}, 64'(busy_a), 64'd1);
        wait_done(tag);
        check_eq({tag, "_pdata_hold"}, pdata_a, exp);
        check_eq({tag, "_busy_at_done"}, 64'(busy_a), 64'd0);
        @(negedge clk);
        check_eq({tag, "_one_start"}, 64'(starts_a - s0), 64'd1);
        check_eq({tag, "_one_done"}, 64'(dones_a - d0), 64'd1);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [7:0]  p;
        logic [7:0]  b;
        logic [63:0] exp_a;
        int s0;
        int d0;
        int k;

        rst_a = 1'b0; rst_b = 1'b0; hold_low = 1'b0;
        disp = 32'd0; point = 8'd0; blank = 8'd0; update_a = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_pdata", pdata_a, 64'hFFFF_FFFF_FFFF_FFFF);
        check_eq("rst_start", 64'(start_a), 64'd0);
        check_eq("rst_busy", 64'(busy_a), 64'd0);
        check_eq("rst_done", 64'(done_a), 64'd0);
        check_eq("rst_err", 64'(err_a), 64'd0);
        rst_a = 1'b1; rst_b = 1'b1;
        repeat (6) @(negedge clk);
        check_eq("no_auto_start", 64'(starts_a), 64'd0);

        // Digits 0..7 in order.
        send_frame(32'h7654_3210, 8'h00, 8'h00, 64'hF8829299_B0A4F9C0, "t1");
        // Point on digit 0, blank overrides digit 7.
        send_frame(32'h8000_0000, 8'h01, 8'h80, model_frame(32'h8000_0000, 8'h01, 8'h80), "t2");
        check_eq("t2_byte0", 64'(pdata_a[7:0]), 64'h40);
        check_eq("t2_byte7", 64'(pdata_a[63:56]), 64'hFF);
        // Blank wins over point on the same digit.
        send_frame(32'hFFFF_FFFF, 8'hFF, 8'h0F, model_frame(32'hFFFF_FFFF, 8'hFF, 8'h0F), "blank_vs_dp");

        // Randomized frames with random shift lengths.
        for (int i = 0; i < 16; i++) begin
            shift_len = int'($urandom_range(1, 12));
            d = $urandom; p = 8'($urandom); b = 8'($urandom) & 8'($urandom);
            send_frame(d, p, b, model_frame(d, p, b), "rand");
        end

        // Three requests while busy coalesce; second frame uses encode-time inputs.
        shift_len = 10;
        wait_idle("t3");
        d = $urandom; p = 8'($urandom); b = 8'h00;
        exp_a = model_frame(d, p, b);
        disp = d; point = p; blank = b; update_a = 1'b1;
        s0 = starts_a; d0 = dones_a;
        @(negedge clk);
        update_a = 1'b0;
        frames_sent++;
        check_eq("t3_first_pdata", pdata_a, exp_a);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            d = $urandom; p = 8'($urandom); b = 8'($urandom) & 8'h0F;
            disp = d; point = p; blank = b; update_a = 1'b1;
            @(negedge clk);
            update_a = 1'b0;
        end
        check_eq("t3_midframe_hold", pdata_a, exp_a);
        wait_done("t3a");
        check_eq("t3_hold_at_done", pdata_a, exp_a);
        @(negedge clk);
        frames_sent++;
        check_eq("t3_second_start", 64'(start_a), 64'd1);
        check_eq("t3_second_pdata", pdata_a, model_frame(d, p, b));
        wait_done("t3b");
        repeat (20) @(negedge clk);
        check_eq("t3_two_starts", 64'(starts_a - s0), 64'd2);
        check_eq("t3_two_dones", 64'(dones_a - d0), 64'd2);

        // Request while the shifter reports busy is held, then served with current inputs.
        wait_idle("hold");
        hold_low = 1'b1;
        disp = 32'h1111_1111; point = 8'h00; blank = 8'h00; update_a = 1'b1;
        s0 = starts_a;
        @(negedge clk);
        update_a = 1'b0;
        check_eq("hold_no_start", 64'(start_a), 64'd0);
        repeat (4) @(negedge clk);
        check_eq("hold_still_idle", 64'(busy_a), 64'd0);
        check_eq("hold_start_cnt", 64'(starts_a - s0), 64'd0);
        disp = 32'hABCD_EF01; point = 8'h5A;
        hold_low = 1'b0;
        @(negedge clk);
        frames_sent++;
        check_eq("hold_served_start", 64'(start_a), 64'd1);
        check_eq("hold_served_pdata", pdata_a, model_frame(32'hABCD_EF01, 8'h5A, 8'h00));
        wait_done("hold");

        // Shifter never drops EN: abort after START_WAIT, err set, no done.
        stuck = 1'b1;
        wait_idle("t4");
        disp = 32'h0000_0042; update_a = 1'b1;
        d0 = dones_a;
        @(negedge clk);
        update_a = 1'b0;
        frames_sent++;
        check_eq("t4_start", 64'(start_a), 64'd1);
        k = 0;
        while (busy_a && k < 40) begin
            @(negedge clk);
            k++;
        end
        check_eq("t4_abort_window", 64'(k >= SW && k <= SW + 2), 64'd1);
        check_eq("t4_err", 64'(err_a), 64'd1);
        repeat (3) @(negedge clk);
        check_eq("t4_no_done", 64'(dones_a - d0), 64'd0);
        stuck = 1'b0;
        send_frame(32'h0000_0001, 8'h00, 8'h00, model_frame(32'h0000_0001, 8'h00, 8'h00), "post_err");
        check_eq("err_sticky", 64'(err_a), 64'd1);

        // Reset during WAIT_HIGH.
        shift_len = 10;
        wait_idle("t6");
        disp = 32'h9999_9999; update_a = 1'b1;
        @(negedge clk);
        update_a = 1'b0;
        frames_sent++;
        k = 0;
        while (en_a && k < 20) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        check_eq("t6_busy_before", 64'(busy_a), 64'd1);
        rst_a = 1'b0;
        #1;
        check_eq("t6_busy", 64'(busy_a), 64'd0);
        check_eq("t6_start", 64'(start_a), 64'd0);
        check_eq("t6_pdata", pdata_a, 64'hFFFF_FFFF_FFFF_FFFF);
        check_eq("t6_err_cleared", 64'(err_a), 64'd0);
        @(negedge clk);
        rst_a = 1'b1;
        send_frame(32'h3210_FEDC, 8'h80, 8'h02, model_frame(32'h3210_FEDC, 8'h80, 8'h02), "t6_after");

        repeat (10) @(negedge clk);
        check_eq("no_refresh_starts", 64'(starts_a), 64'(frames_sent));
        check_eq("refresh_seen", 64'(starts_b >= 3), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
